// File: rtl/noc_ni_pkg.sv
// noc_ni_pkg: flit field layout, widths, TX FSM encoding and flit packing helper
package noc_ni_pkg;
  localparam int NI_DATA_WIDTH    = 32;
  localparam int NI_ADDR_WIDTH    = 3;
  localparam int NI_SEQ_WIDTH     = 8;
  localparam int NI_PAYLOAD_WIDTH = 18;
  localparam int NI_DST_LSB = 0;
  localparam int NI_DST_MSB = 2;
  localparam int NI_SRC_LSB = 3;
  localparam int NI_SRC_MSB = 5;
  localparam int NI_SEQ_LSB = 6;
  localparam int NI_SEQ_MSB = 13;
  localparam int NI_PAY_LSB = 14;
  localparam int NI_PAY_MSB = 31;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_STALL} tx_state_e;
  function automatic logic [NI_DATA_WIDTH-1:0] ni_pack(
    input logic [NI_ADDR_WIDTH-1:0]    dst,
    input logic [NI_ADDR_WIDTH-1:0]    src,
    input logic [NI_SEQ_WIDTH-1:0]     seq,
    input logic [NI_PAYLOAD_WIDTH-1:0] payload
  );
    return {payload, seq, src, dst};
  endfunction
endpackage

// File: rtl/ni_sync_fifo.sv
// ni_sync_fifo: first-word-fall-through synchronous FIFO; push while full is taken only alongside a pop
module ni_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rptr];
  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  // storage array, no reset needed since reads are gated by occupancy
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end
endmodule

// File: rtl/noc_local_ni.sv
// noc_local_ni: host<->router local-port NI; optional RX sequence checking under NI_SEQ_CHECK_EN
module noc_local_ni
  import noc_ni_pkg::*;
#(
  parameter logic [2:0] NODE_ADDRESS = 3'b000,
  parameter int          TXQ_DEPTH    = 4,
  parameter int          RXQ_DEPTH    = 8,
  parameter int          CNT_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        host_tx_valid,
  output logic                        host_tx_ready,
  input  logic [NI_ADDR_WIDTH-1:0]    host_tx_dst,
  input  logic [NI_PAYLOAD_WIDTH-1:0] host_tx_payload,
  output logic [NI_DATA_WIDTH-1:0]    ni_data_out,
  output logic                        ni_valid_out,
  input  logic                        router_full_in,
  input  logic [NI_DATA_WIDTH-1:0]    router_data_in,
  input  logic                        router_valid_in,
  output logic                        host_rx_valid,
  input  logic                        host_rx_ready,
  output logic [NI_ADDR_WIDTH-1:0]    host_rx_src,
  output logic [NI_SEQ_WIDTH-1:0]     host_rx_seq,
  output logic [NI_PAYLOAD_WIDTH-1:0] host_rx_payload,
  output logic [CNT_WIDTH-1:0]        rx_drop_cnt,
  output logic [CNT_WIDTH-1:0]        rx_misroute_cnt,
  output logic [CNT_WIDTH-1:0]        seq_err_cnt,
  output logic                        tx_busy
);
  tx_state_e                 r_tx_state;
  tx_state_e                 w_tx_next;
  logic [NI_SEQ_WIDTH-1:0]   r_tx_seq [8];
  logic                      r_ni_valid;
  logic [NI_DATA_WIDTH-1:0]  r_ni_data;
  logic                      w_txq_full;
  logic                      w_txq_empty;
  logic                      w_tx_push;
  logic                      w_tx_pop;
  logic [NI_DATA_WIDTH-1:0]  w_tx_flit;
  logic [NI_DATA_WIDTH-1:0]  w_txq_head;
  logic                      w_rxq_full;
  logic                      w_rxq_empty;
  logic                      w_rx_dst_ok;
  logic                      w_rx_push;
  logic                      w_rx_pop;
  logic                      w_rx_drop;
  logic                      w_rx_misroute;
  logic [NI_DATA_WIDTH-1:0]  w_rxq_head;
  logic                      w_unused_rx_dst;
  logic [CNT_WIDTH-1:0]      r_rx_drop_cnt;
  logic [CNT_WIDTH-1:0]      r_rx_misroute_cnt;
  assign host_tx_ready = !w_txq_full;
  assign w_tx_push     = host_tx_valid && !w_txq_full;
  assign w_tx_flit     = ni_pack(host_tx_dst, NODE_ADDRESS, r_tx_seq[host_tx_dst], host_tx_payload);
  assign ni_valid_out  = r_ni_valid;
  assign ni_data_out   = r_ni_data;
  assign tx_busy       = !w_txq_empty || r_ni_valid;
  ni_sync_fifo #(.WIDTH(NI_DATA_WIDTH), .DEPTH(TXQ_DEPTH)) u_txq (
    .clk(clk), .rst(rst), .i_push(w_tx_push), .i_data(w_tx_flit), .i_pop(w_tx_pop),
    .o_data(w_txq_head), .o_full(w_txq_full), .o_empty(w_txq_empty)
  );
  // TX injection control: pop only in SEND while the router has room
  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    case (r_tx_state)
      TX_IDLE:  if (!w_txq_empty) w_tx_next = router_full_in ? TX_STALL : TX_SEND;
      TX_SEND: begin
        w_tx_pop  = !w_txq_empty && !router_full_in;
        w_tx_next = w_txq_empty ? TX_IDLE : (router_full_in ? TX_STALL : TX_SEND);
      end
      TX_STALL: if (!router_full_in) w_tx_next = TX_SEND;
      default:  w_tx_next = TX_IDLE;
    endcase
  end
  // TX state and registered flit output, data forced to zero when not valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_ni_valid <= 1'b0;
      r_ni_data  <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      r_ni_valid <= w_tx_pop;
      r_ni_data  <= w_tx_pop ? w_txq_head : '0;
    end
  end
  // per-destination sequence numbers, advanced on each accepted host message
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_tx_seq[i] <= '0;
    end else if (w_tx_push) begin
      r_tx_seq[host_tx_dst] <= r_tx_seq[host_tx_dst] + 8'd1;
    end
  end
  assign w_rx_dst_ok   = router_data_in[NI_DST_MSB:NI_DST_LSB] == NODE_ADDRESS;
  assign w_rx_pop      = !w_rxq_empty && host_rx_ready;
  assign w_rx_push     = router_valid_in && w_rx_dst_ok && (!w_rxq_full || w_rx_pop);
  assign w_rx_drop     = router_valid_in && w_rx_dst_ok && w_rxq_full && !w_rx_pop;
  assign w_rx_misroute = router_valid_in && !w_rx_dst_ok;
  ni_sync_fifo #(.WIDTH(NI_DATA_WIDTH), .DEPTH(RXQ_DEPTH)) u_rxq (
    .clk(clk), .rst(rst), .i_push(w_rx_push), .i_data(router_data_in), .i_pop(w_rx_pop),
    .o_data(w_rxq_head), .o_full(w_rxq_full), .o_empty(w_rxq_empty)
  );
  assign host_rx_valid   = !w_rxq_empty;
  assign host_rx_src     = host_rx_valid ? w_rxq_head[NI_SRC_MSB:NI_SRC_LSB] : '0;
  assign host_rx_seq     = host_rx_valid ? w_rxq_head[NI_SEQ_MSB:NI_SEQ_LSB] : '0;
  assign host_rx_payload = host_rx_valid ? w_rxq_head[NI_PAY_MSB:NI_PAY_LSB] : '0;
  assign w_unused_rx_dst = ^w_rxq_head[NI_DST_MSB:NI_DST_LSB];
  assign rx_drop_cnt     = r_rx_drop_cnt;
  assign rx_misroute_cnt = r_rx_misroute_cnt;
  // saturating RX status counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_drop_cnt     <= '0;
      r_rx_misroute_cnt <= '0;
    end else begin
      if (w_rx_drop && !(&r_rx_drop_cnt)) r_rx_drop_cnt <= r_rx_drop_cnt + CNT_WIDTH'(1);
      if (w_rx_misroute && !(&r_rx_misroute_cnt)) r_rx_misroute_cnt <= r_rx_misroute_cnt + CNT_WIDTH'(1);
    end
  end
`ifdef NI_SEQ_CHECK_EN
  logic [NI_SEQ_WIDTH-1:0]  r_exp [8];
  logic [CNT_WIDTH-1:0]     r_seq_err_cnt;
  logic [NI_ADDR_WIDTH-1:0] w_rx_src;
  logic [NI_SEQ_WIDTH-1:0]  w_rx_seq;
  assign w_rx_src    = router_data_in[NI_SRC_MSB:NI_SRC_LSB];
  assign w_rx_seq    = router_data_in[NI_SEQ_MSB:NI_SEQ_LSB];
  assign seq_err_cnt = r_seq_err_cnt;
  // expected sequence per source, resynchronised on every accepted flit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_exp[i] <= '0;
      r_seq_err_cnt <= '0;
    end else if (w_rx_push) begin
      r_exp[w_rx_src] <= w_rx_seq + 8'd1;
      if (w_rx_seq != r_exp[w_rx_src] && !(&r_seq_err_cnt)) r_seq_err_cnt <= r_seq_err_cnt + CNT_WIDTH'(1);
    end
  end
`else
  assign seq_err_cnt = '0;
`endif
endmodule

// File: tb/tb_noc_local_ni.sv
// tb_noc_local_ni: directed plan scenarios plus random traffic against a queue-based reference model
module tb_noc_local_ni;
  localparam logic [2:0] NODE = 3'd2;
  logic        clk = 1'b0;
  logic        rst;
  logic        host_tx_valid;
  logic        host_tx_ready;
  logic [2:0]  host_tx_dst;
  logic [17:0] host_tx_payload;
  logic [31:0] ni_data_out;
  logic        ni_valid_out;
  logic        router_full_in;
  logic [31:0] router_data_in;
  logic        router_valid_in;
  logic        host_rx_valid;
  logic        host_rx_ready;
  logic [2:0]  host_rx_src;
  logic [7:0]  host_rx_seq;
  logic [17:0] host_rx_payload;
  logic [15:0] rx_drop_cnt;
  logic [15:0] rx_misroute_cnt;
  logic [15:0] seq_err_cnt;
  logic        tx_busy;
  always #5 clk = ~clk;
  noc_local_ni #(.NODE_ADDRESS(NODE), .TXQ_DEPTH(4), .RXQ_DEPTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
    .host_tx_dst(host_tx_dst), .host_tx_payload(host_tx_payload),
    .ni_data_out(ni_data_out), .ni_valid_out(ni_valid_out), .router_full_in(router_full_in),
    .router_data_in(router_data_in), .router_valid_in(router_valid_in),
    .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
    .host_rx_src(host_rx_src), .host_rx_seq(host_rx_seq), .host_rx_payload(host_rx_payload),
    .rx_drop_cnt(rx_drop_cnt), .rx_misroute_cnt(rx_misroute_cnt), .seq_err_cnt(seq_err_cnt),
    .tx_busy(tx_busy)
  );
  int n_cmp = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  logic [31:0] m_txq [$];
  logic [31:0] m_rxq [$];
  logic [7:0]  m_tseq [8];
  logic [7:0]  m_exp [8];
  bit          m_prev_ok;
  bit          m_vout;
  logic [31:0] m_dout;
  int          m_drop;
  int          m_mis;
  int          m_serr;
  function automatic void m_reset();
    m_txq.delete();
    m_rxq.delete();
    for (int i = 0; i < 8; i++) begin
      m_tseq[i] = '0;
      m_exp[i]  = '0;
    end
    m_prev_ok = 0;
    m_vout = 0;
    m_dout = '0;
    m_drop = 0;
    m_mis = 0;
    m_serr = 0;
  endfunction
  // a flit leaves when the queue was non-empty with the router not full on two consecutive cycles
  function automatic void m_edge();
    bit ok, pop, rpop;
    int tsz, rsz;
    logic [31:0] f;
    tsz = m_txq.size();
    ok  = tsz != 0 && !router_full_in;
    pop = ok && m_prev_ok;
    m_vout = pop;
    m_dout = '0;
    if (pop) m_dout = m_txq.pop_front();
    if (host_tx_valid && tsz < 4) begin
      m_txq.push_back({host_tx_payload, m_tseq[host_tx_dst], NODE, host_tx_dst});
      m_tseq[host_tx_dst] = m_tseq[host_tx_dst] + 8'd1;
    end
    m_prev_ok = ok;
    rsz  = m_rxq.size();
    rpop = rsz != 0 && host_rx_ready;
    if (rpop) void'(m_rxq.pop_front());
    if (router_valid_in) begin
      f = router_data_in;
      if (f[2:0] != NODE) begin
        if (m_mis < 65535) m_mis++;
      end else if (rsz == 8 && !rpop) begin
        if (m_drop < 65535) m_drop++;
      end else begin
        m_rxq.push_back(f);
`ifdef NI_SEQ_CHECK_EN
        if (f[13:6] != m_exp[f[5:3]] && m_serr < 65535) m_serr++;
        m_exp[f[5:3]] = f[13:6] + 8'd1;
`endif
      end
    end
  endfunction
  task automatic check_all();
    logic [31:0] h;
    h = m_rxq.size() != 0 ? m_rxq[0] : 32'd0;
    chk("tx_ready", host_tx_ready, m_txq.size() < 4);
    chk("ni_valid", ni_valid_out, m_vout);
    chk("ni_data", ni_data_out, m_dout);
    chk("tx_busy", tx_busy, m_txq.size() != 0 || m_vout);
    chk("rx_valid", host_rx_valid, m_rxq.size() != 0);
    chk("rx_src", host_rx_src, h[5:3]);
    chk("rx_seq", host_rx_seq, h[13:6]);
    chk("rx_payload", host_rx_payload, h[31:14]);
    chk("drop_cnt", rx_drop_cnt, m_drop);
    chk("misroute_cnt", rx_misroute_cnt, m_mis);
    chk("seq_err_cnt", seq_err_cnt, m_serr);
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst) m_reset();
    else m_edge();
    #1;
    check_all();
  endtask
  task automatic idle_in();
    host_tx_valid = 0;
    host_tx_dst = '0;
    host_tx_payload = '0;
    router_full_in = 0;
    router_valid_in = 0;
    router_data_in = '0;
    host_rx_ready = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask
  task automatic rx_flit(input logic [2:0] src, input logic [7:0] seq, input logic [2:0] dst, input logic [17:0] pay);
    router_valid_in = 1;
    router_data_in = {pay, seq, src, dst};
  endtask
  logic [7:0] g_seq [8];
  int saved;
  initial begin
    rst = 1;
    idle_in();
    m_reset();
    tick();
    tick();
    chk("reset_tx_ready", host_tx_ready, 1);
    rst = 0;
    host_tx_valid = 1;
    host_tx_dst = 3'd5;
    host_tx_payload = 18'h2ABCD;
    tick();
    host_tx_valid = 0;
    tick();
    chk("t1_not_yet", ni_valid_out, 0);
    tick();
    chk("t1_valid", ni_valid_out, 1);
    chk("t1_flit", ni_data_out, {18'h2ABCD, 8'd0, 3'd2, 3'd5});
    host_tx_valid = 1;
    tick();
    host_tx_valid = 0;
    tick();
    tick();
    chk("t1_seq1", ni_data_out[13:6], 8'd1);
    tick();
    router_full_in = 1;
    for (int i = 0; i < 5; i++) begin
      host_tx_valid = 1;
      host_tx_dst = 3'd1;
      host_tx_payload = 18'(i + 16);
      tick();
    end
    host_tx_valid = 0;
    chk("t2_ready_low", host_tx_ready, 0);
    chk("t2_no_valid", ni_valid_out, 0);
    router_full_in = 0;
    for (int i = 0; i < 7; i++) tick();
    chk("t2_idle", tx_busy, 0);
    for (int i = 0; i < 10; i++) begin
      rx_flit(3'd3, 8'(i), NODE, 18'(100 + i));
      tick();
    end
    router_valid_in = 0;
    chk("t3_drop", rx_drop_cnt, 2);
    host_rx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_order", host_rx_payload, 18'(100 + i));
      tick();
    end
    host_rx_ready = 0;
    rx_flit(3'd1, 8'd0, 3'd7, 18'h1);
    tick();
    router_valid_in = 0;
    chk("t4_mis", rx_misroute_cnt, 1);
    chk("t4_rx_empty", host_rx_valid, 0);
    for (int i = 0; i < 8; i++) begin
      rx_flit(3'd4, 8'(i), NODE, 18'(200 + i));
      tick();
    end
    saved = m_drop;
    rx_flit(3'd4, 8'd8, NODE, 18'd208);
    host_rx_ready = 1;
    tick();
    router_valid_in = 0;
    host_rx_ready = 0;
    chk("t5_drop_same", rx_drop_cnt, saved);
    chk("t5_head", host_rx_payload, 18'd201);
    do_reset();
    rx_flit(3'd3, 8'd0, NODE, 18'd1); tick();
    rx_flit(3'd3, 8'd1, NODE, 18'd2); tick();
    rx_flit(3'd3, 8'd3, NODE, 18'd3); tick();
`ifdef NI_SEQ_CHECK_EN
    chk("t6_err_after3", seq_err_cnt, 1);
`else
    chk("t6_err_after3", seq_err_cnt, 0);
`endif
    rx_flit(3'd3, 8'd4, NODE, 18'd4); tick();
`ifdef NI_SEQ_CHECK_EN
    chk("t6_err_after4", seq_err_cnt, 1);
`else
    chk("t6_err_after4", seq_err_cnt, 0);
`endif
    router_valid_in = 0;
    do_reset();
    for (int i = 0; i < 8; i++) g_seq[i] = '0;
    for (int c = 0; c < 4000; c++) begin
      logic [2:0] s;
      logic [2:0] d;
      logic [7:0] q;
      rst = $urandom_range(0, 599) == 0;
      host_tx_valid = $urandom_range(0, 2) != 0;
      host_tx_dst = 3'($urandom);
      host_tx_payload = 18'($urandom);
      router_full_in = (c / 200) % 2 == 1 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 4) == 0;
      host_rx_ready = (c / 300) % 2 == 1 ? $urandom_range(0, 4) == 0 : $urandom_range(0, 3) != 0;
      router_valid_in = $urandom_range(0, 2) != 0;
      s = 3'($urandom);
      d = $urandom_range(0, 4) == 0 ? 3'($urandom) : NODE;
      q = $urandom_range(0, 7) == 0 ? 8'($urandom) : g_seq[s];
      g_seq[s] = q + 8'd1;
      router_data_in = {18'($urandom), q, s, d};
      tick();
    end
    rst = 0;
    idle_in();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
